// File: rtl/decode_issue_pkg.sv
// Shared definitions for the decode/issue stage: instruction field layout,
// opcode classes and the issue-control FSM state encoding.
package decode_pkg;

  localparam int INSTR_W  = 16;
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 16;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;

  localparam logic [3:0] OPC_WR_FIRST = 4'h0;
  localparam logic [3:0] OPC_WR_LAST  = 4'hB;
  localparam logic [3:0] OPC_NW_FIRST = 4'hC;
  localparam logic [3:0] OPC_NW_LAST  = 4'hE;
  localparam logic [3:0] OPC_HALT     = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_writer(input logic [3:0] opc);
    return (opc <= OPC_WR_LAST);
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Bundle of the decoder's instruction, writeback, register-read and issue
// signals. master = surrounding pipeline, slave = decode_issue.
interface decode_issue_if;

  logic [15:0] instr;
  logic        instr_vld;
  logic        instr_rdy;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [3:0]  p0_addr;
  logic [3:0]  p1_addr;
  logic        re0;
  logic        re1;
  logic        iss_vld;
  logic [3:0]  iss_op;
  logic [3:0]  iss_dst;
  logic        iss_we;
  logic        hlt;

  modport master (
    output instr, instr_vld, wb_we, wb_addr,
    input  instr_rdy, p0_addr, p1_addr, re0, re1,
           iss_vld, iss_op, iss_dst, iss_we, hlt
  );

  modport slave (
    input  instr, instr_vld, wb_we, wb_addr,
    output instr_rdy, p0_addr, p1_addr, re0, re1,
           iss_vld, iss_op, iss_dst, iss_we, hlt
  );

endinterface

// File: rtl/decode_issue_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue of a writer,
// cleared on writeback. Optional macro: DECODE_ISSUE_WB_BYPASS_EN.
module decode_scoreboard
  import decode_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [REG_W-1:0]    set_addr,
  input  logic                clr_en,
  input  logic [REG_W-1:0]    clr_addr,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  output logic                hit,
  output logic [NUM_REGS-1:0] pending_nxt
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] lookup;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    clr_mask = '0;
    if (clr_en && (clr_addr != '0)) clr_mask[clr_addr] = 1'b1;
    pending_d = pending_q & ~clr_mask;
    // Set is applied after clear so a same-edge set and clear leaves it set.
    if (set_en && (set_addr != '0)) pending_d[set_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

`ifdef DECODE_ISSUE_WB_BYPASS_EN
  // A register written back this cycle is readable this cycle.
  assign lookup = pending_q & ~clr_mask;
`else
  assign lookup = pending_q;
`endif

  assign hit         = lookup[rs1] | lookup[rs2];
  assign pending_nxt = pending_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: stalls on RAW hazards against the pending-write
// scoreboard, registers issue outputs, and drains pending writes on HALT.
// Optional macro: DECODE_ISSUE_WB_BYPASS_EN (same-cycle writeback bypass).
module decode_issue
  import decode_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decode_issue_if.slave  io
);

  logic [REG_W-1:0]    opc, rd, rs1, rs2;
  logic                instr_halt;
  logic                instr_wr;
  logic                hit;
  logic                hazard;
  logic                rdy;
  logic                accept;
  logic                set_en;
  logic [NUM_REGS-1:0] pending_nxt;

  state_e           state_q, state_d;
  logic             iss_vld_q, iss_vld_d;
  logic             iss_we_q, iss_we_d;
  logic             re_q, re_d;
  logic             hlt_q, hlt_d;
  logic [REG_W-1:0] iss_op_q, iss_op_d;
  logic [REG_W-1:0] iss_dst_q, iss_dst_d;
  logic [REG_W-1:0] p0_q, p0_d;
  logic [REG_W-1:0] p1_q, p1_d;

  assign opc = io.instr[OPC_LSB +: REG_W];
  assign rd  = io.instr[RD_LSB  +: REG_W];
  assign rs1 = io.instr[RS1_LSB +: REG_W];
  assign rs2 = io.instr[RS2_LSB +: REG_W];

  assign instr_halt = (opc == OPC_HALT);
  assign instr_wr   = is_writer(opc);
  assign hazard     = io.instr_vld && !instr_halt && hit;
  assign accept     = io.instr_vld && rdy;
  assign set_en     = accept && !instr_halt && instr_wr;

  decode_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (set_en),
    .set_addr    (rd),
    .clr_en      (io.wb_we),
    .clr_addr    (io.wb_addr),
    .rs1         (rs1),
    .rs2         (rs2),
    .hit         (hit),
    .pending_nxt (pending_nxt)
  );

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // No transfer is offered while reset is asserted.
        rdy = !hazard && !rst;
        if (hazard)                                   state_d = ST_STALL;
        else if (io.instr_vld && instr_halt && !rst)  state_d = ST_DRAIN;
      end
      ST_STALL: if (!hazard)            state_d = ST_RUN;
      ST_DRAIN: if (pending_nxt == '0)  state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    iss_vld_d = accept && !instr_halt;
    iss_we_d  = iss_vld_d && instr_wr && (rd != '0);
    re_d      = iss_vld_d;
    iss_op_d  = iss_vld_d ? opc : iss_op_q;
    iss_dst_d = iss_vld_d ? rd  : iss_dst_q;
    p0_d      = iss_vld_d ? rs1 : p0_q;
    p1_d      = iss_vld_d ? rs2 : p1_q;
    hlt_d     = (state_q == ST_DRAIN) && (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      iss_vld_q <= 1'b0;
      iss_we_q  <= 1'b0;
      re_q      <= 1'b0;
      hlt_q     <= 1'b0;
      iss_op_q  <= '0;
      iss_dst_q <= '0;
      p0_q      <= '0;
      p1_q      <= '0;
    end else begin
      state_q   <= state_d;
      iss_vld_q <= iss_vld_d;
      iss_we_q  <= iss_we_d;
      re_q      <= re_d;
      hlt_q     <= hlt_d;
      iss_op_q  <= iss_op_d;
      iss_dst_q <= iss_dst_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
    end
  end

  assign io.instr_rdy = rdy;
  assign io.iss_vld   = iss_vld_q;
  assign io.iss_we    = iss_we_q;
  assign io.re0       = re_q;
  assign io.re1       = re_q;
  assign io.iss_op    = iss_op_q;
  assign io.iss_dst   = iss_dst_q;
  assign io.p0_addr   = p0_q;
  assign io.p1_addr   = p1_q;
  assign io.hlt       = hlt_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: hand-computed expectations per cycle,
// covering issue, RAW stall, same-edge set/clear, r0, HALT drain and reset.
module tb_decode_issue;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  decode_issue_if bus ();

  decode_issue dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic [15:0] instr, input logic vld,
                       input logic we, input logic [3:0] addr);
    bus.instr     = instr;
    bus.instr_vld = vld;
    bus.wb_we     = we;
    bus.wb_addr   = addr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".iss_vld"}, 16'(bus.iss_vld), 16'h0);
    check({tag, ".iss_we"},  16'(bus.iss_we),  16'h0);
    check({tag, ".re0"},     16'(bus.re0),     16'h0);
    check({tag, ".re1"},     16'(bus.re1),     16'h0);
    check({tag, ".hlt"},     16'(bus.hlt),     16'h0);
    check({tag, ".p0"},      16'(bus.p0_addr), 16'h0);
    check({tag, ".p1"},      16'(bus.p1_addr), 16'h0);
    check({tag, ".op"},      16'(bus.iss_op),  16'h0);
    check({tag, ".dst"},     16'(bus.iss_dst), 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(16'h0000, 1'b0, 1'b0, 4'h0);
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // r3 = r1 + r2 with an empty scoreboard
    drive(16'h1312, 1'b1, 1'b0, 4'h0);
    check("add.rdy", 16'(bus.instr_rdy), 16'h1);
    tick();
    check("add.iss_vld", 16'(bus.iss_vld), 16'h1);
    check("add.p0",      16'(bus.p0_addr), 16'h1);
    check("add.p1",      16'(bus.p1_addr), 16'h2);
    check("add.dst",     16'(bus.iss_dst), 16'h3);
    check("add.we",      16'(bus.iss_we),  16'h1);
    check("add.op",      16'(bus.iss_op),  16'h1);
    check("add.re",      16'({bus.re0, bus.re1}), 16'h3);

    // Reader of r3 stalls until r3 is written back
    drive(16'hC030, 1'b1, 1'b0, 4'h0);
    check("raw.rdy_c1", 16'(bus.instr_rdy), 16'h0);
    tick();
    check("raw.no_issue", 16'(bus.iss_vld), 16'h0);
    check("raw.re_low",   16'(bus.re0),     16'h0);
    check("raw.we_low",   16'(bus.iss_we),  16'h0);
    check("raw.p0_hold",  16'(bus.p0_addr), 16'h1);
    check("raw.dst_hold", 16'(bus.iss_dst), 16'h3);
    drive(16'hC030, 1'b1, 1'b1, 4'h3);
    check("raw.rdy_wb", 16'(bus.instr_rdy), 16'h0);
    tick();
`ifdef DECODE_ISSUE_WB_BYPASS_EN
    // Stall state ended on the writeback cycle; accepted the cycle after.
    drive(16'hC030, 1'b1, 1'b0, 4'h0);
    check("raw.rdy_after_wb", 16'(bus.instr_rdy), 16'h1);
    tick();
`else
    // One hazard-free stall cycle is needed to return to RUN.
    drive(16'hC030, 1'b1, 1'b0, 4'h0);
    check("raw.rdy_after_wb", 16'(bus.instr_rdy), 16'h0);
    tick();
    check("raw.rdy_run", 16'(bus.instr_rdy), 16'h1);
    tick();
`endif
    check("raw.iss_vld", 16'(bus.iss_vld), 16'h1);
    check("raw.p0",      16'(bus.p0_addr), 16'h3);
    check("raw.op",      16'(bus.iss_op),  16'hC);
    check("raw.we",      16'(bus.iss_we),  16'h0);

    // Writer to r5 on the same edge r5 is written back: r5 stays pending
    drive(16'h0512, 1'b1, 1'b1, 4'h5);
    check("r5.rdy", 16'(bus.instr_rdy), 16'h1);
    tick();
    check("r5.we",  16'(bus.iss_we),  16'h1);
    check("r5.dst", 16'(bus.iss_dst), 16'h5);
    drive(16'hD050, 1'b1, 1'b0, 4'h0);
    check("r5.reader_stall", 16'(bus.instr_rdy), 16'h0);
    tick();
    drive(16'h0000, 1'b0, 1'b1, 4'h5);
    tick();
    drive(16'h0000, 1'b0, 1'b0, 4'h0);
    tick();

    // Writer to r0 issues without a write; reader of r0 never stalls
    drive(16'h2012, 1'b1, 1'b0, 4'h0);
    check("r0w.rdy", 16'(bus.instr_rdy), 16'h1);
    tick();
    check("r0w.iss_vld", 16'(bus.iss_vld), 16'h1);
    check("r0w.we",      16'(bus.iss_we),  16'h0);
    drive(16'hE000, 1'b1, 1'b0, 4'h0);
    check("r0r.rdy", 16'(bus.instr_rdy), 16'h1);
    tick();
    check("r0r.iss_vld", 16'(bus.iss_vld), 16'h1);
    check("r0r.op",      16'(bus.iss_op),  16'hE);

    // HALT with r4 and r7 pending
    drive(16'h3400, 1'b1, 1'b0, 4'h0);
    tick();
    drive(16'h4711, 1'b1, 1'b0, 4'h0);
    tick();
    drive(16'hF047, 1'b1, 1'b0, 4'h0);
    check("halt.rdy", 16'(bus.instr_rdy), 16'h1);
    tick();
    check("halt.no_issue", 16'(bus.iss_vld), 16'h0);
    check("halt.no_read",  16'(bus.re0),     16'h0);
    check("halt.p0_hold",  16'(bus.p0_addr), 16'h1);
    check("halt.hlt0",     16'(bus.hlt),     16'h0);
    drive(16'h0000, 1'b0, 1'b1, 4'h4);
    check("drain.rdy", 16'(bus.instr_rdy), 16'h0);
    tick();
    check("drain.hlt_r4", 16'(bus.hlt), 16'h0);
    drive(16'h0000, 1'b0, 1'b1, 4'h7);
    tick();
    check("drain.hlt_r7", 16'(bus.hlt), 16'h1);
    drive(16'h1312, 1'b1, 1'b0, 4'h0);
    check("done.rdy", 16'(bus.instr_rdy), 16'h0);
    tick();
    check("done.hlt_off", 16'(bus.hlt),     16'h0);
    check("done.no_issue", 16'(bus.iss_vld), 16'h0);
    check("done.rdy2", 16'(bus.instr_rdy), 16'h0);

    // Reset mid-STALL with r3 and r7 pending
    rst = 1'b1;
    drive(16'h0000, 1'b0, 1'b0, 4'h0);
    tick();
    rst = 1'b0;
    drive(16'h0300, 1'b1, 1'b0, 4'h0);
    tick();
    drive(16'h0700, 1'b1, 1'b0, 4'h0);
    tick();
    check("pre.dst", 16'(bus.iss_dst), 16'h7);
    drive(16'hC037, 1'b1, 1'b0, 4'h0);
    check("pre.stall", 16'(bus.instr_rdy), 16'h0);
    tick();
    rst = 1'b1;
    drive(16'hC037, 1'b1, 1'b0, 4'h0);
    check("rst.rdy", 16'(bus.instr_rdy), 16'h0);
    tick();
    check_reset_outputs("rst_stall");
    rst = 1'b0;
    drive(16'hC037, 1'b1, 1'b0, 4'h0);
    check("post.rdy", 16'(bus.instr_rdy), 16'h1);
    tick();
    check("post.iss_vld", 16'(bus.iss_vld), 16'h1);
    check("post.p0",      16'(bus.p0_addr), 16'h3);
    check("post.p1",      16'(bus.p1_addr), 16'h7);
    drive(16'h0000, 1'b0, 1'b0, 4'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
